// File: rtl/mux2x1_dataflow.sv
// 2:1 dataflow mux (y = s ? a1 : a0) with a registered copy y_q; y zero latency, y_q one cycle.
// No backpressure. Build with MUX2X1_SEL_CNT_EN to add sel_cnt, a count of rising edges with s=1.
module mux2x1_dataflow #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
`ifdef MUX2X1_SEL_CNT_EN
    ,
    output logic [15:0]      sel_cnt
`endif
);

    // Keep ?: so an unknown select still resolves the bits where a0 and a1 agree.
    assign y = s ? a1 : a0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y;
        end
    end

`ifdef MUX2X1_SEL_CNT_EN
    // Free-running count; wraps at 16'hFFFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_cnt <= '0;
        end else if (s) begin
            sel_cnt <= sel_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux2x1_dataflow.sv
// Directed bench for mux2x1_dataflow: a WIDTH=1 and a WIDTH=8 instance share clk and rst.
module tb_mux2x1_dataflow;

    logic       clk;
    logic       rst;
    logic       a0_1, a1_1, s_1;
    logic       y_1, yq_1;
    logic [7:0] a0_8, a1_8;
    logic       s_8;
    logic [7:0] y_8, yq_8;
`ifdef MUX2X1_SEL_CNT_EN
    logic [15:0] cnt_1, cnt_8;
`endif

    int n_vec;
    int n_err;

    mux2x1_dataflow #(.WIDTH(1)) u_w1 (
        .clk (clk),
        .rst (rst),
        .a0  (a0_1),
        .a1  (a1_1),
        .s   (s_1),
        .y   (y_1),
        .y_q (yq_1)
`ifdef MUX2X1_SEL_CNT_EN
        ,
        .sel_cnt (cnt_1)
`endif
    );

    mux2x1_dataflow #(.WIDTH(8)) u_w8 (
        .clk (clk),
        .rst (rst),
        .a0  (a0_8),
        .a1  (a1_8),
        .s   (s_8),
        .y   (y_8),
        .y_q (yq_8)
`ifdef MUX2X1_SEL_CNT_EN
        ,
        .sel_cnt (cnt_8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [2:0] tt_in  [8];
    logic       tt_exp [8];
    logic [7:0] mask;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst  = 1'b1;
        a0_1 = 1'b0; a1_1 = 1'b0; s_1 = 1'b0;
        a0_8 = 8'h00; a1_8 = 8'h00; s_8 = 1'b0;

        // Reset state
        #2;
        check("rst_yq_w1", {15'd0, yq_1}, 16'h0000);
        check("rst_yq_w8", {8'd0, yq_8}, 16'h0000);

        // Truth table {s,a1,a0} -> y
        tt_in[0] = 3'b000; tt_exp[0] = 1'b0;
        tt_in[1] = 3'b001; tt_exp[1] = 1'b1;
        tt_in[2] = 3'b010; tt_exp[2] = 1'b0;
        tt_in[3] = 3'b011; tt_exp[3] = 1'b1;
        tt_in[4] = 3'b100; tt_exp[4] = 1'b0;
        tt_in[5] = 3'b101; tt_exp[5] = 1'b0;
        tt_in[6] = 3'b110; tt_exp[6] = 1'b1;
        tt_in[7] = 3'b111; tt_exp[7] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {s_1, a1_1, a0_1} = tt_in[i];
            #1;
            check($sformatf("truth_%0d", i), {15'd0, y_1}, {15'd0, tt_exp[i]});
        end

        // Toggle stimulus: a0 every 1ns, a1 every 2ns, s every 4ns
        for (int t = 0; t < 8; t++) begin
            a0_1 = t[0];
            a1_1 = t[1];
            s_1  = t[2];
            #0.5;
            check($sformatf("toggle_t%0d", t), {15'd0, y_1},
                  {15'd0, (t < 4) ? t[0] : t[1]});
            #0.5;
        end

        // WIDTH=8 select and register, out of reset
        @(negedge clk);
        rst = 1'b0;
        a0_8 = 8'h3C; a1_8 = 8'hA5; s_8 = 1'b0;
        #1;
        check("w8_s0_y", {8'd0, y_8}, 16'h003C);
        s_8 = 1'b1;
        #1;
        check("w8_s1_y", {8'd0, y_8}, 16'h00A5);
        @(posedge clk);
        #1;
        check("w8_yq_load", {8'd0, yq_8}, 16'h00A5);

        // Async reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("arst_yq_now", {8'd0, yq_8}, 16'h0000);
        check("arst_y_kept", {8'd0, y_8}, 16'h00A5);
        @(posedge clk);
        #1;
        check("arst_yq_hold", {8'd0, yq_8}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_yq_midcyc", {8'd0, yq_8}, 16'h0000);
        @(posedge clk);
        #1;
        check("rel_yq_load", {8'd0, yq_8}, 16'h00A5);

        // Unknown select: agreeing bits resolve (differing bits are X in 4-state sims)
        @(negedge clk);
        a0_1 = 1'b1; a1_1 = 1'b1; s_1 = 1'bx;
        a0_8 = 8'hF0; a1_8 = 8'hF5; s_8 = 1'bx;
        #1;
        check("selx_w1_agree", {15'd0, y_1}, 16'h0001);
        mask = ~(a0_8 ^ a1_8);
        check("selx_w8_agree", {8'd0, y_8 & mask}, 16'h00F0);
        s_1 = 1'b0; s_8 = 1'b0;

`ifdef MUX2X1_SEL_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("cnt_rst", cnt_8, 16'h0000);
        s_8 = 1'b1;
        repeat (5) @(negedge clk);
        s_8 = 1'b0;
        repeat (3) @(negedge clk);
        check("cnt_5of8", cnt_8, 16'd5);
        s_8 = 1'b1;
        repeat (65530) @(negedge clk);
        check("cnt_ffff", cnt_8, 16'hFFFF);
        @(negedge clk);
        check("cnt_wrap", cnt_8, 16'h0000);
        s_8 = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
